// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-port signals shared by the imem arbiter and its clients
interface imem_arbiter_if #(parameter int ADDR_W = 30, parameter int DATA_W = 32);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_en, m_we, m_addr, m_wdata
  );
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch/loader arbiter for a single-port imem; IMEM_ARB_STARVE_EN enables loader anti-starvation
module imem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  imem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, FETCH, LOAD} own_t;
  own_t own;
  logic force_l;
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("imem_arbiter: STARVE_MAX must be in 1..15");
  end
`ifdef IMEM_ARB_STARVE_EN
  logic [3:0] scnt;
  assign force_l = bus.l_req && scnt == 4'(STARVE_MAX);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scnt <= '0;
    else
      scnt <= (bus.l_req && !bus.l_gnt) ? (scnt == 4'(STARVE_MAX) ? scnt : scnt + 4'd1) : '0;
  end
`else
  assign force_l = 1'b0;
`endif
  always_comb begin
    bus.f_gnt   = bus.f_req & ~force_l;
    bus.l_gnt   = bus.l_req & (force_l | ~bus.f_req);
    bus.m_en    = bus.f_gnt | bus.l_gnt;
    bus.m_we    = bus.l_gnt & bus.l_we;
    bus.m_addr  = bus.l_gnt ? bus.l_addr : bus.f_gnt ? bus.f_addr : '0;
    bus.m_wdata = bus.l_gnt ? bus.l_wdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      own <= NONE;
    else
      own <= bus.f_gnt ? FETCH : (bus.l_gnt && !bus.l_we) ? LOAD : NONE;
  end
  assign bus.f_rvalid = own == FETCH;
  assign bus.l_rvalid = own == LOAD;
  assign bus.f_rdata  = bus.m_rdata;
  assign bus.l_rdata  = bus.m_rdata;
endmodule
